// File: rtl/filter_rr_arbiter_pkg.sv
// filter_rr_arbiter_pkg
//   Shared definitions for the filter read-side arbiter.
//   - Default field widths of a filtered pair.
//   - Pair word layout, MSB to LSB: {ref_id, neighbor_id, r2, dz, dy, dx}.
//   - field_lsb() gives field offsets for non-default widths.
package filter_rr_arbiter_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int PARTICLE_ID_WIDTH = 20;
    localparam int PAIR_WIDTH        = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH;

    localparam int DX_LSB  = 0;
    localparam int DY_LSB  = DATA_WIDTH;
    localparam int DZ_LSB  = 2*DATA_WIDTH;
    localparam int R2_LSB  = 3*DATA_WIDTH;
    localparam int NID_LSB = 4*DATA_WIDTH;
    localparam int RID_LSB = 4*DATA_WIDTH + PARTICLE_ID_WIDTH;

    typedef enum logic [2:0] {
        FLD_DX,
        FLD_DY,
        FLD_DZ,
        FLD_R2,
        FLD_NID,
        FLD_RID
    } pair_field_e;

    function automatic int field_lsb(input pair_field_e f, input int dw, input int pw);
        case (f)
            FLD_DX:  return 0;
            FLD_DY:  return dw;
            FLD_DZ:  return 2*dw;
            FLD_R2:  return 3*dw;
            FLD_NID: return 4*dw;
            FLD_RID: return 4*dw + pw;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/filter_rr_arbiter_rr_grant_select.sv
// rr_grant_select
//   Combinational round-robin pick: returns the first set request bit found
//   when searching last_grant+1, last_grant+2, ... modulo N.
//   Ports:
//     req        in  N          request vector
//     last_grant in  IDX_WIDTH  index granted most recently
//     grant      out IDX_WIDTH  selected index (0 when nothing found)
//     found      out 1          at least one request bit set
module rr_grant_select #(
    parameter int N         = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic [IDX_WIDTH-1:0] grant,
    output logic                 found
);
    import filter_rr_arbiter_pkg::*;

    always_comb begin
        int                   cand;
        logic [IDX_WIDTH-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        grant    = '0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(last_grant) + k) % N;
            cand_idx = cand[IDX_WIDTH-1:0];
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                grant = cand_idx;
            end
        end
    end

endmodule

// File: rtl/filter_rr_arbiter.sv
// filter_rr_arbiter
//   Round-robin read arbiter for a bank of filter buffers feeding one force
//   pipeline. Pulses one buffer read request per cycle, captures the pair
//   returned the following cycle and presents it through a registered,
//   stallable output backed by a single-entry hold register.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     pair_available            per-buffer non-empty flags
//     filter_pair_data          buffer read data, slice i = buffer i
//     sel                       one-hot read request (combinational)
//     out_stall                 downstream cannot accept this cycle
//     out_valid                 output pair valid
//     *_out                     output pair fields
//     out_filter_idx            source buffer of the output pair
//     arbiter_idle              nothing available, in flight, held or valid
module filter_rr_arbiter #(
    parameter int  DATA_WIDTH        = filter_rr_arbiter_pkg::DATA_WIDTH,
    parameter int  PARTICLE_ID_WIDTH = filter_rr_arbiter_pkg::PARTICLE_ID_WIDTH,
    parameter int  NUM_FILTER        = 4,
    parameter int  FILTER_IDX_WIDTH  = 2,
    localparam int PAIR_WIDTH        = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FILTER-1:0]            pair_available,
    input  logic [NUM_FILTER*PAIR_WIDTH-1:0] filter_pair_data,
    output logic [NUM_FILTER-1:0]            sel,
    input  logic                             out_stall,
    output logic                             out_valid,
    output logic [PARTICLE_ID_WIDTH-1:0]     ref_particle_id_out,
    output logic [PARTICLE_ID_WIDTH-1:0]     neighbor_particle_id_out,
    output logic [DATA_WIDTH-1:0]            r2_out,
    output logic [DATA_WIDTH-1:0]            dz_out,
    output logic [DATA_WIDTH-1:0]            dy_out,
    output logic [DATA_WIDTH-1:0]            dx_out,
    output logic [FILTER_IDX_WIDTH-1:0]      out_filter_idx,
    output logic                             arbiter_idle
);
    import filter_rr_arbiter_pkg::*;

    localparam int L_DX  = field_lsb(FLD_DX,  DATA_WIDTH, PARTICLE_ID_WIDTH);
    localparam int L_DY  = field_lsb(FLD_DY,  DATA_WIDTH, PARTICLE_ID_WIDTH);
    localparam int L_DZ  = field_lsb(FLD_DZ,  DATA_WIDTH, PARTICLE_ID_WIDTH);
    localparam int L_R2  = field_lsb(FLD_R2,  DATA_WIDTH, PARTICLE_ID_WIDTH);
    localparam int L_NID = field_lsb(FLD_NID, DATA_WIDTH, PARTICLE_ID_WIDTH);
    localparam int L_RID = field_lsb(FLD_RID, DATA_WIDTH, PARTICLE_ID_WIDTH);

    logic [FILTER_IDX_WIDTH-1:0] last_grant;
    logic [FILTER_IDX_WIDTH-1:0] grant;
    logic                        found;
    logic                        issue;
    logic                        held;
    logic                        rd_pending;
    logic [FILTER_IDX_WIDTH-1:0] rd_idx;
    logic                        hold_valid;
    logic [PAIR_WIDTH-1:0]       hold_pair;
    logic [FILTER_IDX_WIDTH-1:0] hold_idx;
    logic [PAIR_WIDTH-1:0]       out_pair;
    logic [PAIR_WIDTH-1:0]       slices [NUM_FILTER];
    logic [PAIR_WIDTH-1:0]       q;

    for (genvar i = 0; i < NUM_FILTER; i++) begin : g_slice
        assign slices[i] = filter_pair_data[i*PAIR_WIDTH +: PAIR_WIDTH];
    end

    assign q = slices[rd_idx];

    rr_grant_select #(
        .N         (NUM_FILTER),
        .IDX_WIDTH (FILTER_IDX_WIDTH)
    ) u_grant (
        .req        (pair_available),
        .last_grant (last_grant),
        .grant      (grant),
        .found      (found)
    );

    assign held = out_valid && out_stall;

    // Issuing only when unstalled with an empty hold guarantees the pair
    // returned next cycle always has somewhere to go: the output register if
    // it frees up, otherwise the (empty) hold register.
    assign issue = !rst && !out_stall && !hold_valid && found;

    always_comb begin
        sel = '0;
        if (issue) begin
            sel[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant     <= FILTER_IDX_WIDTH'(NUM_FILTER-1);
            rd_pending     <= 1'b0;
            rd_idx         <= '0;
            hold_valid     <= 1'b0;
            hold_pair      <= '0;
            hold_idx       <= '0;
            out_valid      <= 1'b0;
            out_pair       <= '0;
            out_filter_idx <= '0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                last_grant <= grant;
                rd_idx     <= grant;
            end
            if (!held) begin
                // Hold is older than any pair in flight, so it drains first.
                if (hold_valid) begin
                    out_valid      <= 1'b1;
                    out_pair       <= hold_pair;
                    out_filter_idx <= hold_idx;
                    hold_valid     <= 1'b0;
                end else if (rd_pending) begin
                    out_valid      <= 1'b1;
                    out_pair       <= q;
                    out_filter_idx <= rd_idx;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (rd_pending) begin
                hold_valid <= 1'b1;
                hold_pair  <= q;
                hold_idx   <= rd_idx;
            end
        end
    end

    a_no_second_hold: assert property (@(posedge clk) disable iff (rst)
        !(rd_pending && hold_valid));

    assign ref_particle_id_out      = out_pair[L_RID +: PARTICLE_ID_WIDTH];
    assign neighbor_particle_id_out = out_pair[L_NID +: PARTICLE_ID_WIDTH];
    assign r2_out                   = out_pair[L_R2  +: DATA_WIDTH];
    assign dz_out                   = out_pair[L_DZ  +: DATA_WIDTH];
    assign dy_out                   = out_pair[L_DY  +: DATA_WIDTH];
    assign dx_out                   = out_pair[L_DX  +: DATA_WIDTH];

    assign arbiter_idle = !(|pair_available) && !rd_pending && !hold_valid && !out_valid;

endmodule

// File: tb/tb_filter_rr_arbiter.sv
// tb_filter_rr_arbiter
//   Self-checking bench for filter_rr_arbiter: a directed vector table,
//   hand-written corner sequences and a randomized phase, all checked
//   against a transaction-level reference model plus an ordering scoreboard.
module tb_filter_rr_arbiter;
    import filter_rr_arbiter_pkg::*;

    localparam int NF = 4;
    localparam int PW = PAIR_WIDTH;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NF-1:0]                pair_available;
    logic [NF*PW-1:0]             filter_pair_data;
    logic [NF-1:0]                sel;
    logic                         out_stall;
    logic                         out_valid;
    logic [PARTICLE_ID_WIDTH-1:0] ref_particle_id_out;
    logic [PARTICLE_ID_WIDTH-1:0] neighbor_particle_id_out;
    logic [DATA_WIDTH-1:0]        r2_out, dz_out, dy_out, dx_out;
    logic [1:0]                   out_filter_idx;
    logic                         arbiter_idle;

    always #5 clk = ~clk;

    filter_rr_arbiter dut (
        .clk                      (clk),
        .rst                      (rst),
        .pair_available           (pair_available),
        .filter_pair_data         (filter_pair_data),
        .sel                      (sel),
        .out_stall                (out_stall),
        .out_valid                (out_valid),
        .ref_particle_id_out      (ref_particle_id_out),
        .neighbor_particle_id_out (neighbor_particle_id_out),
        .r2_out                   (r2_out),
        .dz_out                   (dz_out),
        .dy_out                   (dy_out),
        .dx_out                   (dx_out),
        .out_filter_idx           (out_filter_idx),
        .arbiter_idle             (arbiter_idle)
    );

    // Reference model: pairs granted but not yet presented, oldest first.
    // 'arrived' marks a pair that has come back from its buffer and is waiting.
    typedef struct {
        logic [PW-1:0] w;
        int            idx;
        bit            arrived;
    } item_t;

    typedef struct {
        bit            r;
        logic [NF-1:0] av;
        bit            st;
        logic [NF-1:0] sel;
        bit            chk_out;
        bit            ov;
        int            idx;
        bit            zero;
    } vec_t;

    item_t         pipe[$];
    logic [PW-1:0] sb[$];
    int            m_last;
    bit            m_ov;
    logic [PW-1:0] m_out;
    int            m_oidx;
    bit            m_known;
    bit            preset_en [NF];
    logic [PW-1:0] preset_w  [NF];
    int            n_cmp, n_err;
    logic [NF-1:0] obs_sel;
    logic          obs_ov;
    logic [PW-1:0] obs_out;
    bit            tv_en;
    vec_t          tv;
    vec_t          vecs [21];

    function automatic logic [PW-1:0] out_word();
        return {ref_particle_id_out, neighbor_particle_id_out, r2_out, dz_out, dy_out, dx_out};
    endfunction

    function automatic logic [PW-1:0] rand_pair();
        logic [191:0] t;
        for (int j = 0; j < 6; j++) t[j*32 +: 32] = $urandom();
        return t[PW-1:0];
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input logic [NF-1:0] av, input bit st);
        logic [NF-1:0] esel;
        int            g, c;
        bit            iss, held, hold_full;
        logic [PW-1:0] w_for [NF];
        item_t         it;

        @(negedge clk);
        rst            = r;
        pair_available = av;
        out_stall      = st;
        #1;
        obs_sel = sel;
        obs_ov  = out_valid;
        obs_out = out_word();

        hold_full = 0;
        foreach (pipe[j]) if (pipe[j].arrived) hold_full = 1;
        iss  = 0;
        g    = 0;
        esel = '0;
        if (!r && !st && !hold_full) begin
            for (int k = 1; k <= NF; k++) begin
                c = (m_last + k) % NF;
                if (!iss && av[c]) begin
                    iss = 1;
                    g   = c;
                end
            end
        end
        if (iss) esel[g] = 1'b1;

        chk("sel", sel, esel);
        if (m_known) begin
            chk("out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("out_pair", obs_out, m_out);
                chk("out_filter_idx", out_filter_idx, m_oidx);
            end
            chk("arbiter_idle", arbiter_idle, (av == '0) && !m_ov && (pipe.size() == 0));
        end
        if (tv_en) begin
            chk("vec_sel", sel, tv.sel);
            if (tv.chk_out) begin
                chk("vec_out_valid", out_valid, tv.ov);
                if (tv.ov) chk("vec_out_filter_idx", out_filter_idx, tv.idx);
            end
            if (tv.zero) chk("vec_out_zero", obs_out, '0);
        end

        // Ordering scoreboard: every accepted output must be the oldest grant.
        if (!r && out_valid === 1'b1 && !st) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_order: actual %0h required <no pending grant>", obs_out);
            end else begin
                it.w = sb.pop_front();
                if (obs_out !== it.w) begin
                    n_err++;
                    $display("FAIL sb_order: actual %0h required %0h", obs_out, it.w);
                end
            end
        end
        if (r) sb.delete();

        for (int i = 0; i < NF; i++) begin
            w_for[i] = preset_en[i] ? preset_w[i] : rand_pair();
            if (obs_sel[i] === 1'b1) begin
                sb.push_back(w_for[i]);
                preset_en[i] = 0;
            end
        end

        if (r) begin
            m_last  = NF - 1;
            m_ov    = 0;
            m_out   = '0;
            m_oidx  = 0;
            pipe.delete();
            m_known = 1;
        end else begin
            held = m_ov && st;
            if (!held) begin
                if (pipe.size() > 0) begin
                    it     = pipe.pop_front();
                    m_ov   = 1;
                    m_out  = it.w;
                    m_oidx = it.idx;
                end else begin
                    m_ov = 0;
                end
            end else begin
                foreach (pipe[j]) pipe[j].arrived = 1;
            end
            if (iss) begin
                m_last = g;
                pipe.push_back('{w: w_for[g], idx: g, arrived: 1'b0});
            end
        end

        @(posedge clk);
        #1;
        // Read data appears one cycle after the request; unread slices carry noise.
        for (int i = 0; i < NF; i++)
            filter_pair_data[i*PW +: PW] = (obs_sel[i] === 1'b1) ? w_for[i] : rand_pair();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] single_w;
        logic [PW-1:0] stall_snap;
        logic [NF-1:0] av;

        n_cmp = 0; n_err = 0; m_known = 0; tv_en = 0;
        m_last = NF - 1; m_ov = 0; m_out = '0; m_oidx = 0;
        rst = 1'b1; pair_available = '0; out_stall = 1'b0;
        filter_pair_data = '0;
        for (int i = 0; i < NF; i++) begin
            preset_en[i] = 0;
            preset_w[i]  = '0;
        end

        //           r  av       st sel      chk ov idx zero
        vecs[0]  = '{1, 4'b1111, 0, 4'b0000, 0, 0, 0, 0};
        vecs[1]  = '{1, 4'b1111, 0, 4'b0000, 1, 0, 0, 1};
        vecs[2]  = '{1, 4'b1111, 0, 4'b0000, 1, 0, 0, 1};
        vecs[3]  = '{0, 4'b1111, 0, 4'b0001, 1, 0, 0, 1};
        vecs[4]  = '{0, 4'b1111, 0, 4'b0010, 1, 0, 0, 0};
        vecs[5]  = '{0, 4'b1111, 0, 4'b0100, 1, 1, 0, 0};
        vecs[6]  = '{0, 4'b1111, 0, 4'b1000, 1, 1, 1, 0};
        vecs[7]  = '{0, 4'b1111, 0, 4'b0001, 1, 1, 2, 0};
        vecs[8]  = '{0, 4'b1111, 0, 4'b0010, 1, 1, 3, 0};
        vecs[9]  = '{0, 4'b1111, 0, 4'b0100, 1, 1, 0, 0};
        vecs[10] = '{0, 4'b1111, 0, 4'b1000, 1, 1, 1, 0};
        vecs[11] = '{0, 4'b0000, 0, 4'b0000, 1, 1, 2, 0};
        vecs[12] = '{0, 4'b0000, 0, 4'b0000, 1, 1, 3, 0};
        vecs[13] = '{0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0};
        vecs[14] = '{0, 4'b1010, 0, 4'b0010, 1, 0, 0, 0};
        vecs[15] = '{0, 4'b1010, 0, 4'b1000, 1, 0, 0, 0};
        vecs[16] = '{0, 4'b1010, 0, 4'b0010, 1, 1, 1, 0};
        vecs[17] = '{0, 4'b1010, 0, 4'b1000, 1, 1, 3, 0};
        vecs[18] = '{0, 4'b0000, 0, 4'b0000, 1, 1, 1, 0};
        vecs[19] = '{0, 4'b0000, 0, 4'b0000, 1, 1, 3, 0};
        vecs[20] = '{0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0};

        tv_en = 1;
        for (int i = 0; i < 21; i++) begin
            tv = vecs[i];
            cycle(tv.r, tv.av, tv.st);
        end
        tv_en = 0;

        // Single pair from buffer 2 with known field values.
        single_w = {20'h00012, 20'h00034, 32'h42C80000, 32'h3F800000, 32'h40000000, 32'h40400000};
        preset_en[2] = 1;
        preset_w[2]  = single_w;
        cycle(0, 4'b0100, 0);
        chk("single_sel", obs_sel, 4'b0100);
        cycle(0, 4'b0000, 0);
        cycle(0, 4'b0000, 0);
        chk("single_valid", obs_ov, 1'b1);
        chk("single_ref", ref_particle_id_out, 20'h00012);
        chk("single_nbr", neighbor_particle_id_out, 20'h00034);
        chk("single_r2", r2_out, 32'h42C80000);
        chk("single_dz", dz_out, 32'h3F800000);
        chk("single_dy", dy_out, 32'h40000000);
        chk("single_dx", dx_out, 32'h40400000);
        chk("single_idx", out_filter_idx, 2'd2);
        cycle(0, 4'b0000, 0);
        chk("single_idle", arbiter_idle, 1'b1);

        // Stall mid-stream on a full bank.
        for (int i = 0; i < 5; i++) cycle(0, 4'b1111, 0);
        cycle(0, 4'b1111, 1);
        stall_snap = obs_out;
        chk("stall_sel", obs_sel, 4'b0000);
        chk("stall_valid", obs_ov, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'b1111, 1);
            chk("stall_sel", obs_sel, 4'b0000);
            chk("stall_stable", obs_out, stall_snap);
        end
        for (int i = 0; i < 8; i++) cycle(0, 4'b1111, 0);

        // Reset while a read is in flight.
        cycle(1, 4'b1111, 0);
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_data", out_word(), '0);
        cycle(0, 4'b1111, 0);
        chk("rst_mid_first_sel", obs_sel, 4'b0001);
        for (int i = 0; i < 6; i++) cycle(0, 4'b0000, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            av = 4'($urandom());
            if ($urandom_range(0, 3) == 0) av = 4'b1111;
            cycle(($urandom_range(0, 99) == 0), av, ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 8; i++) cycle(0, 4'b0000, 0);
        chk("sb_drained", sb.size(), 0);
        chk("final_idle", arbiter_idle, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/filter_rr_arbiter.md
Name: filter_rr_arbiter

Overview:
- Read-side arbiter for a bank of filter buffers. Each buffer holds pairs that passed the r2 cutoff.
- Each cycle it grants at most one non-empty buffer, round-robin, by pulsing that buffer's read request.
- It captures the returned pair and presents it to the force pipeline through a registered output with stall support.
- It sits between the NUM_FILTER filter instances and one force pipeline.

Parameters:
- DATA_WIDTH, 32, width of the float fields r2/dx/dy/dz.
- PARTICLE_ID_WIDTH, 20, width of each particle ID.
- NUM_FILTER, 4, number of filters arbitrated.
- FILTER_IDX_WIDTH, 2, clog2(NUM_FILTER).
- Derived localparam PAIR_WIDTH = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH (168 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pair_available  in  NUM_FILTER  bit i high when buffer i is non-empty.
- filter_pair_data  in  NUM_FILTER*PAIR_WIDTH  slice i at [i*PAIR_WIDTH +: PAIR_WIDTH] is buffer i read data. Field order MSB-LSB: {ref_id, neighbor_id, r2, dz, dy, dx}.
- sel  out  NUM_FILTER  one-hot read request to buffers, combinational.
- out_stall  in  1  force pipeline cannot accept data this cycle.
- out_valid  out  1  output pair valid.
- ref_particle_id_out  out  PARTICLE_ID_WIDTH
- neighbor_particle_id_out  out  PARTICLE_ID_WIDTH
- r2_out, dz_out, dy_out, dx_out  out  DATA_WIDTH each.
- out_filter_idx  out  FILTER_IDX_WIDTH  source filter of the current output.
- arbiter_idle  out  1  all buffers empty, no read in flight, hold register empty, out_valid low.

Behaviour:
- Buffer read timing: data for a read request asserted in cycle t is valid on that buffer's slice in cycle t+1.
- Issue condition in cycle t: out_stall==0 AND hold_valid==0 AND |pair_available.
- Grant: first set bit of pair_available, searching last_grant+1, last_grant+2, … with wrap modulo NUM_FILTER. sel = onehot(grant) when the issue condition holds, else 0. At most one sel bit high in any cycle.
- On issue: last_grant <= grant; rd_pending <= 1; rd_idx <= grant.
- When no issue: rd_pending <= 0.
- In the cycle with rd_pending==1, q = slice rd_idx is captured:
  - if out is not held (!(out_valid && out_stall)): q goes to the output register; out_valid=1 next cycle;
  - else q goes to the hold register; hold_valid=1.
- Output register update in a cycle where out is not held:
  - source priority is hold register first, then q;
  - with neither present, out_valid <= 0.
- Data/valid/idx stay stable while out_valid && out_stall.
- Invariant: rd_pending and hold refill never require a second hold entry. Issue is blocked whenever out is held or hold is full. Verify with an assertion: q never arrives while hold_valid==1.
- Latency: sel in cycle t -> out_valid in t+2 when unstalled.
- Throughput: one pair/cycle when the bank never goes empty.
- Ordering: output order equals grant order; no loss, no duplication.
- Reset (any cycle, including with a read in flight):
  - sel, out_valid, hold_valid and rd_pending go to 0; all output data/idx go to 0;
  - last_grant <= NUM_FILTER-1, so filter 0 is granted first;
  - data from a read in flight is discarded, because the whole pipeline resets together;
  - arbiter_idle = 1 in the cycle after reset once pair_available==0.
- pair_available bit falling while not granted: no effect.
- Buffers are only ever read through sel.

Decomposition:
- Shared package: PAIR_WIDTH, field offsets of the pair word (DX_LSB, DY_LSB, DZ_LSB, R2_LSB, NID_LSB, RID_LSB), and the default widths DATA_WIDTH/PARTICLE_ID_WIDTH.
- One sub-module: rr_grant_select. It is combinational and takes request vector + last_grant, returning grant index and found flag. It is reusable for other arbiters in the design.
- The skid/hold and output register stay in the top module.

Test Plan:
- Reset: assert rst 3 cycles with pair_available=4'b1111 -> sel=0, out_valid=0, all data 0. First grant after release is sel=4'b0001.
- Single pair: only buffer 2 available for one cycle with slice 2 = {ref 20'h00012, nbr 20'h00034, r2 32'h42C80000, dz/dy/dx = 1.0/2.0/3.0}.
  - sel=4'b0100 at t.
  - out_valid=1 at t+2 with those exact fields and out_filter_idx=2.
  - arbiter_idle=1 from t+3.
- Full bank: pair_available=4'b1111 held 8 cycles, no stall -> sel sequence 1,2,4,8,1,2,4,8; out_valid continuous from the 3rd cycle; out_filter_idx 0,1,2,3,0,…
- Sparse requests: pair_available=4'b1010 -> grants alternate idx 1,3,1,3. No sel on bits 0 or 2.
- Stall mid-stream: full bank; raise out_stall for 4 cycles one cycle after a grant.
  - held output stays stable;
  - in-flight pair goes to hold;
  - sel=0 during the stall;
  - after release: held pair, then hold pair, then new grants continuing round-robin. Scoreboard confirms no loss/dup.
- Reset mid-operation: assert rst on the cycle rd_pending==1 -> next cycle out_valid=0, hold_valid=0, no stale pair emitted after release, next grant sel=4'b0001.
